// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, ALU ops,
// datapath mux selects and opcode constants.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_TRAP
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [1:0] ASEL_PC    = 2'b00;
    localparam logic [1:0] ASEL_OLDPC = 2'b01;
    localparam logic [1:0] ASEL_RS1   = 2'b10;

    localparam logic [1:0] BSEL_RS2  = 2'b00;
    localparam logic [1:0] BSEL_IMM  = 2'b01;
    localparam logic [1:0] BSEL_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // funct3 011 (sltu) has no ALU op; the FSM traps before it is used.
    function automatic logic [2:0] alu_op_from_funct3(input logic [2:0] f3, input logic is_sub);
        logic [2:0] op;
        op = ALU_ADD;
        case (f3)
            3'b000:  op = is_sub ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mc_branch_cond.sv
// Branch-taken decision from funct3 and ALU flags of rs1-rs2.
// MC_FULL_BRANCH_EN selects the full condition set; otherwise only beq can be taken.
module mc_branch_cond (
    input  logic [2:0] i_funct3,
    input  logic       i_n,
    input  logic       i_z,
    input  logic       i_c,
    input  logic       i_v,
    output logic       o_taken
);

`ifdef MC_FULL_BRANCH_EN
    always_comb begin
        o_taken = 1'b0;
        case (i_funct3)
            3'b000:  o_taken = i_z;
            3'b001:  o_taken = !i_z;
            3'b100:  o_taken = i_n ^ i_v;
            3'b101:  o_taken = !(i_n ^ i_v);
            3'b110:  o_taken = !i_c;
            3'b111:  o_taken = i_c;
            default: o_taken = 1'b0;
        endcase
    end
`else
    logic w_unused_flags;

    assign w_unused_flags = ^{i_n, i_c, i_v};
    assign o_taken        = (i_funct3 == 3'b000) & i_z;
`endif

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I core (shared ALU, unified memory port).
// MC_FULL_BRANCH_EN enables all six branch conditions and traps funct3 010/011.
//   state    | meaning
//   FETCH    | read instr at PC, PC <= PC+4 when memory ready
//   DECODE   | ALUOut <= OldPC+imm, dispatch on opcode
//   MEMADR   | ALUOut <= rs1+imm
//   MEMREAD  | read data at ALUOut until ready
//   MEMWB    | rd <= mem data
//   MEMWRITE | write data at ALUOut until ready
//   EXECR/I  | ALUOut <= rs1 op rs2/imm
//   ALUWB    | rd <= ALUOut
//   BRANCH   | compare rs1-rs2, PC <= target if taken
//   JAL      | PC <= target, ALUOut <= OldPC+4
//   TRAP     | unsupported instruction, held until reset
module multicycle_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       N,
    input  logic       Z,
    input  logic       C,
    input  logic       V,
    input  logic       mem_ready,
    output logic       pc_wren,
    output logic       ir_wren,
    output logic       dmem_wren,
    output logic       regfile_wren,
    output logic       adr_sel,
    output logic [1:0] ALU_asel,
    output logic [1:0] ALU_bsel,
    output logic [1:0] result_sel,
    output logic [1:0] ximm_sel,
    output logic [2:0] ALU_control,
    output logic       instr_done,
    output logic       illegal
);

    state_t r_state;
    state_t w_next;
    logic   w_taken;

    mc_branch_cond u_branch_cond (
        .i_funct3 (funct3),
        .i_n      (N),
        .i_z      (Z),
        .i_c      (C),
        .i_v      (V),
        .o_taken  (w_taken)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        pc_wren      = 1'b0;
        ir_wren      = 1'b0;
        dmem_wren    = 1'b0;
        regfile_wren = 1'b0;
        adr_sel      = 1'b0;
        ALU_asel     = ASEL_PC;
        ALU_bsel     = BSEL_RS2;
        result_sel   = RES_ALUOUT;
        ximm_sel     = IMM_I;
        ALU_control  = ALU_ADD;
        instr_done   = 1'b0;
        illegal      = 1'b0;

        case (r_state)
            S_FETCH: begin
                ALU_asel   = ASEL_PC;
                ALU_bsel   = BSEL_FOUR;
                result_sel = RES_ALU;
                if (mem_ready) begin
                    ir_wren = 1'b1;
                    pc_wren = 1'b1;
                    w_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                ALU_asel = ASEL_OLDPC;
                ALU_bsel = BSEL_IMM;
                if (opcode == OP_BR)       ximm_sel = IMM_B;
                else if (opcode == OP_JAL) ximm_sel = IMM_J;
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECR;
                    OP_I:         w_next = S_EXECI;
`ifdef MC_FULL_BRANCH_EN
                    OP_BR:        w_next = (funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
`else
                    OP_BR:        w_next = S_BRANCH;
`endif
                    OP_JAL:       w_next = S_JAL;
                    default:      w_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALU_asel = ASEL_RS1;
                ALU_bsel = BSEL_IMM;
                ximm_sel = (opcode == OP_SW) ? IMM_S : IMM_I;
                w_next   = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_sel = 1'b1;
                if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_sel   = RES_MEMDATA;
                regfile_wren = 1'b1;
                instr_done   = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_sel   = 1'b1;
                dmem_wren = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    w_next     = S_FETCH;
                end
            end
            S_EXECR, S_EXECI: begin
                ALU_asel    = ASEL_RS1;
                ALU_bsel    = (r_state == S_EXECR) ? BSEL_RS2 : BSEL_IMM;
                ALU_control = alu_op_from_funct3(funct3, (r_state == S_EXECR) && funct7b5);
                w_next      = (funct3 == 3'b011) ? S_TRAP : S_ALUWB;
            end
            S_ALUWB: begin
                result_sel   = RES_ALUOUT;
                regfile_wren = 1'b1;
                instr_done   = 1'b1;
                w_next       = S_FETCH;
            end
            S_BRANCH: begin
                ALU_asel    = ASEL_RS1;
                ALU_bsel    = BSEL_RS2;
                ALU_control = ALU_SUB;
                pc_wren     = w_taken;
                instr_done  = 1'b1;
                w_next      = S_FETCH;
            end
            S_JAL: begin
                pc_wren  = 1'b1;
                ALU_asel = ASEL_OLDPC;
                ALU_bsel = BSEL_FOUR;
                w_next   = S_ALUWB;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase

        // Reset overrides everything that could commit architectural state.
        if (reset) begin
            pc_wren      = 1'b0;
            ir_wren      = 1'b0;
            dmem_wren    = 1'b0;
            regfile_wren = 1'b0;
            instr_done   = 1'b0;
            w_next       = S_FETCH;
        end
    end

endmodule
